// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) xtime, word helpers and the key-schedule FSM state type.
package aes_pkg;

    localparam int AES128_NK = 4;
    localparam int AES128_NR = 10;
    localparam int AES256_NK = 8;
    localparam int AES256_NR = 14;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box byte lookup; shared by the key schedule and the iterative cipher datapath.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] result
);

    assign result = SBOX[data];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key schedule: one 32-bit schedule word per clock into a flat round-key vector.
// Optional AES_KEXP_ZEROIZE_EN clears the derived words on the start edge.
//
//   state  | meaning
//   IDLE   | waiting for start; expanded_key valid when key_valid is high
//   EXPAND | writing w[idx] each clock until w[NW-1]
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter  int NK = AES256_NK,
    parameter  int NR = AES256_NR,
    localparam int NW = 4 * (NR + 1),
    localparam int KW = 32 * NW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [32*NK-1:0] key_in,
    output logic            busy,
    output logic            done,
    output logic            key_valid,
    output logic [KW-1:0]   expanded_key
);

    localparam int IW = $clog2(NW + 1);
    localparam int PW = (NK > 1) ? $clog2(NK) : 1;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [PW-1:0]  phase;
    logic [7:0]     rcon;
    // Sliding window of the last NK words: win[0] = w[i-NK], win[NK-1] = w[i-1].
    logic [31:0]    win [NK];

    logic [31:0]    prev_word;
    logic [31:0]    sbox_in;
    logic [31:0]    sub_out;
    logic [31:0]    temp;
    logic [31:0]    new_word;

    assign prev_word = win[NK-1];
    assign sbox_in   = (phase == '0) ? rot_word(prev_word) : prev_word;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .data   (sbox_in[8*g +: 8]),
            .result (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        temp = prev_word;
        if (phase == '0) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if ((NK > 6) && (int'(phase) == 4)) begin
            temp = sub_out;
        end
        new_word = win[0] ^ temp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            key_valid    <= 1'b0;
            expanded_key <= '0;
            idx          <= '0;
            phase        <= '0;
            rcon         <= 8'h01;
            for (int k = 0; k < NK; k++) begin
                win[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        expanded_key[KW-1 -: 32*NK] <= key_in;
`ifdef AES_KEXP_ZEROIZE_EN
                        expanded_key[KW-32*NK-1:0] <= '0;
`endif
                        for (int k = 0; k < NK; k++) begin
                            win[k] <= key_in[32*NK-1-32*k -: 32];
                        end
                        idx       <= IW'(NK);
                        phase     <= '0;
                        rcon      <= 8'h01;
                        key_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int k = NK; k < NW; k++) begin
                        if (idx == IW'(k)) begin
                            expanded_key[KW-1-32*k -: 32] <= new_word;
                        end
                    end
                    for (int k = 0; k < NK - 1; k++) begin
                        win[k] <= win[k+1];
                    end
                    win[NK-1] <= new_word;
                    idx       <= idx + 1'b1;
                    phase     <= (phase == PW'(NK - 1)) ? '0 : phase + 1'b1;
                    if (phase == '0) begin
                        rcon <= xtime(rcon);
                    end
                    if (idx == IW'(NW - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
